// File: rtl/dual_port_ram.sv
// dual_port_ram
// True dual-port synchronous RAM shared by two independent agents on one clock.
// Both ports can read or write any word on every rising edge of clk.
//
// Ports (X = 0 or 1):
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset; clears every word and both read registers
//   cs_pX        port chip select, active high
//   wr_rd_pX     1 = write, 0 = read
//   out_en_pX    output enable; when low data_out_pX floats ('z)
//   address_pX   word address
//   data_in_pX   write data
//   data_out_pX  read data, one cycle after the read is sampled
//
// Collision behaviour on a single edge:
//   write/write to the same word  -> port 0 data is stored
//   write/read to the same word   -> the reader sees the old contents
//   read/read to the same word    -> both readers get the same data
module dual_port_ram #(
    parameter int DATA_WIDTH   = 8,
    parameter int MEMORY_DEPTH = 32,
    parameter int ADDR_SIZE    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_p0,
    input  logic                  wr_rd_p0,
    input  logic                  out_en_p0,
    input  logic [ADDR_SIZE-1:0]  address_p0,
    input  logic [DATA_WIDTH-1:0] data_in_p0,
    output logic [DATA_WIDTH-1:0] data_out_p0,
    input  logic                  cs_p1,
    input  logic                  wr_rd_p1,
    input  logic                  out_en_p1,
    input  logic [ADDR_SIZE-1:0]  address_p1,
    input  logic [DATA_WIDTH-1:0] data_in_p1,
    output logic [DATA_WIDTH-1:0] data_out_p1
);

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
    logic [DATA_WIDTH-1:0] rd_reg_p0;
    logic [DATA_WIDTH-1:0] rd_reg_p1;

    logic wr_en_p0;
    logic wr_en_p1;
    logic rd_en_p0;
    logic rd_en_p1;

    assign wr_en_p0 = cs_p0 &  wr_rd_p0;
    assign wr_en_p1 = cs_p1 &  wr_rd_p1;
    assign rd_en_p0 = cs_p0 & ~wr_rd_p0;
    assign rd_en_p1 = cs_p1 & ~wr_rd_p1;

    // Storage. Port 1 is written first so that a port 0 write to the same
    // word in the same edge overrides it (last non-blocking update wins).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEMORY_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en_p1) begin
                mem[address_p1] <= data_in_p1;
            end
            if (wr_en_p0) begin
                mem[address_p0] <= data_in_p0;
            end
        end
    end

    // Read registers sample the pre-edge array contents, which gives
    // read-before-write on a same-word collision. They hold during writes
    // and while deselected, so there is no write-through.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_reg_p0 <= '0;
            rd_reg_p1 <= '0;
        end else begin
            if (rd_en_p0) begin
                rd_reg_p0 <= mem[address_p0];
            end
            if (rd_en_p1) begin
                rd_reg_p1 <= mem[address_p1];
            end
        end
    end

    // Output enable only gates the pins; it never touches stored state.
    assign data_out_p0 = out_en_p0 ? rd_reg_p0 : {DATA_WIDTH{1'bz}};
    assign data_out_p1 = out_en_p1 ? rd_reg_p1 : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_dual_port_ram.sv
module tb_dual_port_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_p0, wr_rd_p0, out_en_p0;
    logic [4:0] address_p0;
    logic [7:0] data_in_p0;
    logic [7:0] data_out_p0;
    logic       cs_p1, wr_rd_p1, out_en_p1;
    logic [4:0] address_p1;
    logic [7:0] data_in_p1;
    logic [7:0] data_out_p1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dual_port_ram #(.DATA_WIDTH(8), .MEMORY_DEPTH(32), .ADDR_SIZE(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .cs_p0       (cs_p0),
        .wr_rd_p0    (wr_rd_p0),
        .out_en_p0   (out_en_p0),
        .address_p0  (address_p0),
        .data_in_p0  (data_in_p0),
        .data_out_p0 (data_out_p0),
        .cs_p1       (cs_p1),
        .wr_rd_p1    (wr_rd_p1),
        .out_en_p1   (out_en_p1),
        .address_p1  (address_p1),
        .data_in_p1  (data_in_p1),
        .data_out_p1 (data_out_p1)
    );

    // One table row = one clock edge of stimulus on both ports.
    // A read row carries the value that port must return one edge later.
    typedef struct {
        string      name;
        logic       cs0;
        logic       wr0;
        logic [4:0] a0;
        logic [7:0] d0;
        logic [7:0] e0;
        logic       cs1;
        logic       wr1;
        logic [4:0] a1;
        logic [7:0] d1;
        logic [7:0] e1;
    } vec_t;

    typedef struct {
        string      name;
        bit         port;
        logic [7:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vt[$];

    function automatic vec_t mk(string name,
                                logic cs0, logic wr0, logic [4:0] a0, logic [7:0] d0, logic [7:0] e0,
                                logic cs1, logic wr1, logic [4:0] a1, logic [7:0] d1, logic [7:0] e1);
        vec_t v;
        v.name = name;
        v.cs0 = cs0; v.wr0 = wr0; v.a0 = a0; v.d0 = d0; v.e0 = e0;
        v.cs1 = cs1; v.wr1 = wr1; v.a1 = a1; v.d1 = d1; v.e1 = e1;
        return v;
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Drive one edge, queue expectations for reads, then drain the
    // scoreboard once the registered data is visible.
    task automatic apply(vec_t v);
        sb_t e;
        @(negedge clk);
        cs_p0 = v.cs0; wr_rd_p0 = v.wr0; address_p0 = v.a0; data_in_p0 = v.d0;
        cs_p1 = v.cs1; wr_rd_p1 = v.wr1; address_p1 = v.a1; data_in_p1 = v.d1;
        if (v.cs0 && !v.wr0) begin
            e.name = {v.name, "_p0"}; e.port = 1'b0; e.exp = v.e0;
            sb_q.push_back(e);
        end
        if (v.cs1 && !v.wr1) begin
            e.name = {v.name, "_p1"}; e.port = 1'b1; e.exp = v.e1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cs_p0 = 1'b0; cs_p1 = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, e.port ? data_out_p1 : data_out_p0, e.exp);
        end
    endtask

    initial begin
        logic [7:0] zval;
        zval = 8'hzz;

        rst = 1'b1;
        cs_p0 = 1'b0; wr_rd_p0 = 1'b0; out_en_p0 = 1'b1; address_p0 = '0; data_in_p0 = '0;
        cs_p1 = 1'b0; wr_rd_p1 = 1'b0; out_en_p1 = 1'b1; address_p1 = '0; data_in_p1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_p0", data_out_p0, 8'h00);
        check("reset_out_p1", data_out_p1, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        //            name         cs0 wr0 a0  d0     e0     cs1 wr1 a1  d1     e1
        vt.push_back(mk("rst_rd_a", 1, 0,  0, 8'h00, 8'h00, 1, 0,  0, 8'h00, 8'h00));
        vt.push_back(mk("rst_rd_b", 1, 0, 17, 8'h00, 8'h00, 1, 0, 31, 8'h00, 8'h00));
        vt.push_back(mk("rst_rd_c", 1, 0, 31, 8'h00, 8'h00, 1, 0, 17, 8'h00, 8'h00));
        vt.push_back(mk("wr_basic", 1, 1,  3, 8'hA5, 8'h00, 1, 1, 28, 8'h3C, 8'h00));
        vt.push_back(mk("rd_basic", 1, 0, 28, 8'h00, 8'h3C, 1, 0,  3, 8'h00, 8'hA5));
        vt.push_back(mk("wr_coll",  1, 1, 10, 8'h11, 8'h00, 1, 1, 10, 8'h22, 8'h00));
        vt.push_back(mk("rd_coll",  1, 0, 10, 8'h00, 8'h11, 1, 0, 10, 8'h00, 8'h11));
        vt.push_back(mk("wr_55",    1, 1,  5, 8'h55, 8'h00, 0, 0,  0, 8'h00, 8'h00));
        vt.push_back(mk("rw_coll",  1, 1,  5, 8'h66, 8'h00, 1, 0,  5, 8'h00, 8'h55));
        vt.push_back(mk("rw_after", 1, 0,  5, 8'h00, 8'h66, 1, 0,  5, 8'h00, 8'h66));
        vt.push_back(mk("wr_rev",   1, 0, 20, 8'h00, 8'h00, 1, 1, 20, 8'h77, 8'h00));
        vt.push_back(mk("rd_rev",   1, 0, 20, 8'h00, 8'h77, 1, 0, 28, 8'h00, 8'h3C));

        foreach (vt[i]) apply(vt[i]);

        // Output enable gates only the pins.
        apply(mk("oe_setup", 1, 0, 3, 8'h00, 8'hA5, 1, 0, 28, 8'h00, 8'h3C));
        out_en_p0 = 1'b0;
        #1;
        check("oe_low_p0", data_out_p0, zval);
        check("oe_low_p1_unaffected", data_out_p1, 8'h3C);
        out_en_p0 = 1'b1;
        #1;
        check("oe_high_p0", data_out_p0, 8'hA5);

        // Deselected port ignores wr_rd/address/data activity.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cs_p0 = 1'b0; wr_rd_p0 = i[0]; address_p0 = 5'(i * 7 + 3); data_in_p0 = 8'hEE;
            @(posedge clk);
            #1;
        end
        check("cs_low_hold_p0", data_out_p0, 8'hA5);

        // A write on the port leaves its read register alone.
        apply(mk("wr_no_wt", 1, 1, 9, 8'h99, 8'h00, 0, 0, 0, 8'h00, 8'h00));
        check("wr_hold_p0", data_out_p0, 8'hA5);
        apply(mk("cs_mem_chk", 1, 0, 3, 8'h00, 8'hA5, 1, 0, 10, 8'h00, 8'h11));
        apply(mk("cs_mem_chk2", 1, 0, 17, 8'h00, 8'h00, 1, 0, 9, 8'h00, 8'h99));

        // Reset wins over a write in the same edge.
        @(negedge clk);
        rst = 1'b1;
        cs_p0 = 1'b1; wr_rd_p0 = 1'b1; address_p0 = 5'd7; data_in_p0 = 8'hFF;
        @(posedge clk);
        #1;
        check("midrst_rdreg_p0", data_out_p0, 8'h00);
        check("midrst_rdreg_p1", data_out_p1, 8'h00);
        @(negedge clk);
        rst = 1'b0; cs_p0 = 1'b0;
        apply(mk("midrst_rd7", 1, 0, 7, 8'h00, 8'h00, 1, 0, 3, 8'h00, 8'h00));
        apply(mk("midrst_rd5", 1, 0, 5, 8'h00, 8'h00, 1, 0, 10, 8'h00, 8'h00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
